// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
// Round-robin arbiter that lets core_count cores share one single-port
// synchronous data RAM. Each core raises req (with we/addr/wdata) and holds it
// until its one-cycle ack. One access takes three cycles: select (IDLE),
// RAM access (ISSUE), and response (RESP).
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req, we             per-core request and write enable
//   addr, wdata         packed per-core address / write data (core i at slice i)
//   ack                 one-hot one-cycle completion pulse
//   rdata               read data, valid while ack is high for a read
//   busy                transaction in flight (ISSUE or RESP)
//   grant_id            core currently or last served
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata   single-port RAM interface
module core_mem_arbiter #(
  parameter int core_count = 2,
  parameter int addr_width = 12,
  parameter int data_width = 12,
  localparam int gw = (core_count > 1) ? $clog2(core_count) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [core_count-1:0]            req,
  input  logic [core_count-1:0]            we,
  input  logic [core_count*addr_width-1:0] addr,
  input  logic [core_count*data_width-1:0] wdata,
  output logic [core_count-1:0]            ack,
  output logic [data_width-1:0]            rdata,
  output logic                             busy,
  output logic [gw-1:0]                    grant_id,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [addr_width-1:0]            mem_addr,
  output logic [data_width-1:0]            mem_wdata,
  input  logic [data_width-1:0]            mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [gw-1:0] last_id    = gw'(core_count - 1);
  localparam logic [gw:0]   count_wide = (gw + 1)'(core_count);

  state_t                 state_reg, state_next;
  logic [gw-1:0]          rr_ptr_reg, rr_ptr_next;
  logic                   write_reg, write_next;
  logic [core_count-1:0]  ack_next;
  logic [data_width-1:0]  rdata_next;
  logic                   busy_next;
  logic [gw-1:0]          grant_next;
  logic                   mem_en_next, mem_we_next;
  logic [addr_width-1:0]  mem_addr_next;
  logic [data_width-1:0]  mem_wdata_next;

  // The core being acked this cycle is masked so a req it is still dropping
  // cannot win a second grant.
  logic [core_count-1:0]   eligible;
  logic [2*core_count-1:0] eligible_dbl, eligible_shift;
  logic [core_count-1:0]   rotated, first_hit;
  logic [gw-1:0]           offset, sel;
  logic [gw:0]             sum, wrapped;

  logic [addr_width-1:0] addr_slice  [core_count];
  logic [data_width-1:0] wdata_slice [core_count];

  assign eligible       = req & ~ack;
  // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit of
  // rotated is the first eligible core scanning upward from rr_ptr with wrap.
  assign eligible_dbl   = {eligible, eligible};
  assign eligible_shift = eligible_dbl >> rr_ptr_reg;
  assign rotated        = eligible_shift[core_count-1:0];

  genvar gi, gb;
  generate
    for (gi = 0; gi < core_count; gi++) begin : g_core
      if (gi == 0) begin : g_first
        assign first_hit[gi] = rotated[gi];
      end else begin : g_rest
        assign first_hit[gi] = rotated[gi] & ~(|rotated[gi-1:0]);
      end
      assign addr_slice[gi]  = addr[gi*addr_width +: addr_width];
      assign wdata_slice[gi] = wdata[gi*data_width +: data_width];
      assign ack_next[gi]    = (state_reg == RESP) && (grant_id == gw'(gi));
    end

    // One-hot to binary: bit gb of the offset is set if the winning position
    // has bit gb set in its index.
    for (gb = 0; gb < gw; gb++) begin : g_enc
      logic [core_count-1:0] bit_mask;
      for (gi = 0; gi < core_count; gi++) begin : g_mask
        assign bit_mask[gi] = ((gi >> gb) & 1) != 0;
      end
      assign offset[gb] = |(first_hit & bit_mask);
    end
  endgenerate

  // Map the rotated position back to a core index (modulo core_count).
  assign sum     = {1'b0, rr_ptr_reg} + {1'b0, offset};
  assign wrapped = (sum >= count_wide) ? (sum - count_wide) : sum;
  assign sel     = wrapped[gw-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      write_reg  <= 1'b0;
      ack        <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      write_reg  <= write_next;
      ack        <= ack_next;
      rdata      <= rdata_next;
      busy       <= busy_next;
      grant_id   <= grant_next;
      mem_en     <= mem_en_next;
      mem_we     <= mem_we_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    write_next     = write_reg;
    rdata_next     = rdata;
    busy_next      = busy;
    grant_next     = grant_id;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          grant_next     = sel;
          write_next     = we[sel];
          mem_en_next    = 1'b1;
          mem_we_next    = we[sel];
          mem_addr_next  = addr_slice[sel];
          mem_wdata_next = wdata_slice[sel];
          busy_next      = 1'b1;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        // RAM samples mem_* on this edge; address and data are held.
        state_next = RESP;
      end
      RESP: begin
        if (!write_reg) begin
          rdata_next = mem_rdata;
        end
        busy_next   = 1'b0;
        rr_ptr_next = (grant_id == last_id) ? '0 : grant_id + gw'(1);
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: core_count = 2
  logic [1:0]      req_a, we_a, ack_a;
  logic [2*AW-1:0] addr_a;
  logic [2*DW-1:0] wdata_a;
  logic [DW-1:0]   rdata_a, mem_wdata_a, mem_rdata_a;
  logic            busy_a, mem_en_a, mem_we_a;
  logic [0:0]      grant_a;
  logic [AW-1:0]   mem_addr_a;

  // Instance B: core_count = 3
  logic [2:0]      req_b, we_b, ack_b;
  logic [3*AW-1:0] addr_b;
  logic [3*DW-1:0] wdata_b;
  logic [DW-1:0]   rdata_b, mem_wdata_b, mem_rdata_b;
  logic            busy_b, mem_en_b, mem_we_b;
  logic [1:0]      grant_b;
  logic [AW-1:0]   mem_addr_b;

  core_mem_arbiter #(.core_count(2), .addr_width(AW), .data_width(DW)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .ack(ack_a), .rdata(rdata_a), .busy(busy_a), .grant_id(grant_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  core_mem_arbiter #(.core_count(3), .addr_width(AW), .data_width(DW)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .grant_id(grant_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // Synchronous single-port RAMs with registered read.
  logic [DW-1:0] ram_a [0:4095];
  logic [DW-1:0] ram_b [0:4095];
  logic [DW-1:0] model_a [0:4095];
  logic [DW-1:0] model_b [0:4095];

  always @(posedge clk) begin
    if (mem_en_a) begin
      if (mem_we_a) ram_a[mem_addr_a] <= mem_wdata_a;
      mem_rdata_a <= ram_a[mem_addr_a];
    end
    if (mem_en_b) begin
      if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
      mem_rdata_b <= ram_b[mem_addr_b];
    end
  end

  typedef struct {
    logic [2:0]    ack;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int vectors = 0;
  int errors  = 0;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a) ^ 12'h3C3;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit inst, input logic [2:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.ack = a;
    e.rdata = d;
    if (inst) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  // Waits (bounded) for an ack pulse; n is the number of negedges waited.
  task automatic wait_ack(input bit inst, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((inst ? |ack_b : |ack_a) == 1'b0) && n < 20);
    cmp("ack_seen", 32'(inst ? |ack_b : |ack_a), 32'd1);
  endtask

  task automatic sb_check(input bit inst, input string tag);
    exp_t e;
    if ((inst ? q_b.size() : q_a.size()) == 0) begin
      cmp({tag, "_unexpected_ack"}, inst ? 32'(ack_b) : 32'(ack_a), 32'd0);
    end else begin
      e = inst ? q_b.pop_front() : q_a.pop_front();
      cmp({tag, "_ack"},   inst ? 32'(ack_b) : 32'(ack_a), 32'(e.ack));
      cmp({tag, "_rdata"}, inst ? 32'(rdata_b) : 32'(rdata_a), 32'(e.rdata));
    end
    $display("txn %s inst=%0d ack=%0b rdata=%0h", tag, inst, inst ? ack_b : {1'b0, ack_a},
             inst ? rdata_b : rdata_a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DW-1:0] last_a;

    reset = 1'b1;
    req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
    for (int i = 0; i < 4096; i++) begin
      ram_a[i]   <= init_val(i);
      ram_b[i]   <= init_val(i);
      model_a[i] = init_val(i);
      model_b[i] = init_val(i);
    end
    ram_a[12'h010]   <= 12'hABC;
    model_a[12'h010] = 12'hABC;

    repeat (2) @(negedge clk);
    cmp("rst_ack",      32'(ack_a), 0);
    cmp("rst_busy",     32'(busy_a), 0);
    cmp("rst_mem_en",   32'(mem_en_a), 0);
    cmp("rst_rdata",    32'(rdata_a), 0);
    cmp("rst_grant",    32'(grant_a), 0);
    cmp("rst_mem_addr", 32'(mem_addr_a), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single read by core0, fixed-latency checks.
    req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0 +: AW] = 12'h010;
    push(0, 3'b001, model_a[12'h010]);
    @(negedge clk);
    cmp("rd_mem_en",   32'(mem_en_a), 1);
    cmp("rd_mem_we",   32'(mem_we_a), 0);
    cmp("rd_mem_addr", 32'(mem_addr_a), 32'h010);
    cmp("rd_busy1",    32'(busy_a), 1);
    @(negedge clk);
    cmp("rd_mem_en_off", 32'(mem_en_a), 0);
    cmp("rd_busy2",      32'(busy_a), 1);
    cmp("rd_ack_early",  32'(ack_a), 0);
    @(negedge clk);
    sb_check(0, "rd0");
    cmp("rd_busy_done", 32'(busy_a), 0);
    req_a[0] = 1'b0;
    last_a = 12'hABC;
    @(negedge clk);
    cmp("rd_ack_width", 32'(ack_a), 0);

    // Core1 write then read back.
    req_a[1] = 1'b1; we_a[1] = 1'b1; addr_a[AW +: AW] = 12'h0FF; wdata_a[DW +: DW] = 12'h5A5;
    push(0, 3'b010, last_a);
    model_a[12'h0FF] = 12'h5A5;
    @(negedge clk);
    cmp("wr_mem_we",    32'(mem_we_a), 1);
    cmp("wr_mem_addr",  32'(mem_addr_a), 32'h0FF);
    cmp("wr_mem_wdata", 32'(mem_wdata_a), 32'h5A5);
    cmp("wr_grant",     32'(grant_a), 1);
    wait_ack(0, n);
    cmp("wr_latency", 32'(n), 2);
    sb_check(0, "wr1");
    req_a[1] = 1'b0; we_a[1] = 1'b0;
    @(negedge clk);
    req_a[1] = 1'b1;
    push(0, 3'b010, model_a[12'h0FF]);
    wait_ack(0, n);
    cmp("rb_latency", 32'(n), 3);
    sb_check(0, "rb1");
    req_a[1] = 1'b0;
    @(negedge clk);

    // Both cores requesting from reset: grants alternate 0,1,0,1,0,1.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    addr_a[0 +: AW] = 12'h020; addr_a[AW +: AW] = 12'h021; we_a = '0;
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) push(0, 3'b001, model_a[12'h020]);
      else            push(0, 3'b010, model_a[12'h021]);
    end
    req_a = 2'b11;
    for (int t = 0; t < 6; t++) begin
      wait_ack(0, n);
      cmp("rr_grant", 32'(grant_a), 32'(t % 2));
      sb_check(0, "rr");
      if (t == 5) req_a = 2'b00;
      @(negedge clk);
      cmp("rr_ack_width", 32'(ack_a), 0);
    end
    @(negedge clk);
    cmp("rr_idle_busy", 32'(busy_a), 0);

    // Ack masking: core0 holds req one cycle past its ack.
    addr_a[0 +: AW] = 12'h030;
    req_a[0] = 1'b1;
    push(0, 3'b001, model_a[12'h030]);
    wait_ack(0, n);
    sb_check(0, "mask");
    @(negedge clk);
    cmp("mask_ack",    32'(ack_a), 0);
    cmp("mask_mem_en", 32'(mem_en_a), 0);
    cmp("mask_busy",   32'(busy_a), 0);
    req_a[0] = 1'b0;
    @(negedge clk);
    cmp("mask_mem_en2", 32'(mem_en_a), 0);
    cmp("mask_busy2",   32'(busy_a), 0);
    // rr_ptr is now 1, so core1 wins the next contention.
    addr_a[0 +: AW] = 12'h040; addr_a[AW +: AW] = 12'h041;
    push(0, 3'b010, model_a[12'h041]);
    push(0, 3'b001, model_a[12'h040]);
    req_a = 2'b11;
    wait_ack(0, n);
    sb_check(0, "ptr1_first");
    req_a[1] = 1'b0;
    wait_ack(0, n);
    sb_check(0, "ptr1_second");
    req_a[0] = 1'b0;
    @(negedge clk);

    // Async reset while in ISSUE.
    addr_a[0 +: AW] = 12'h050;
    req_a[0] = 1'b1;
    @(negedge clk);
    cmp("ar_mem_en_pre", 32'(mem_en_a), 1);
    #2 reset = 1'b1;
    #1;
    cmp("ar_mem_en", 32'(mem_en_a), 0);
    cmp("ar_busy",   32'(busy_a), 0);
    cmp("ar_ack",    32'(ack_a), 0);
    cmp("ar_grant",  32'(grant_a), 0);
    req_a[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    addr_a[AW +: AW] = 12'h060;
    req_a[1] = 1'b1;
    push(0, 3'b010, model_a[12'h060]);
    wait_ack(0, n);
    cmp("ar_latency", 32'(n), 3);
    sb_check(0, "ar_fresh");
    req_a[1] = 1'b0;
    @(negedge clk);

    // core_count=3 wrap: serve core1 (rr_ptr -> 2), then cores 0 and 1 contend.
    addr_b[AW +: AW] = 12'h070;
    req_b[1] = 1'b1;
    push(1, 3'b010, model_b[12'h070]);
    wait_ack(1, n);
    cmp("w3_latency", 32'(n), 3);
    sb_check(1, "w3_setup");
    req_b[1] = 1'b0;
    @(negedge clk);
    addr_b[0 +: AW] = 12'h080; addr_b[AW +: AW] = 12'h081;
    push(1, 3'b001, model_b[12'h080]);
    push(1, 3'b010, model_b[12'h081]);
    req_b = 3'b011;
    wait_ack(1, n);
    cmp("w3_grant0", 32'(grant_b), 0);
    sb_check(1, "w3_first");
    req_b[0] = 1'b0;
    wait_ack(1, n);
    cmp("w3_grant1", 32'(grant_b), 1);
    sb_check(1, "w3_second");
    req_b[1] = 1'b0;
    @(negedge clk);
    cmp("q_a_drained", 32'(q_a.size()), 0);
    cmp("q_b_drained", 32'(q_b.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Round-robin arbiter sharing one single-port synchronous data RAM between the `core_count` cores of the multi-core processor.
- Each core issues one read or write through a req/ack handshake.
- The arbiter serialises accesses, drives the RAM port and returns read data with a one-cycle ack pulse.
- Sits between the per-core datapaths and the shared data memory, inside the top-level processor.

Parameters:
- core_count, 2, number of requesting cores (>=1, need not be a power of two).
- addr_width, 12, data-memory address width.
- data_width, 12, data word width (matches core register width).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  core_count  per-core access request; held high until the matching ack.
- we  input  core_count  per-core write enable (1=write, 0=read); stable while req is high.
- addr  input  core_count*addr_width  packed per-core addresses; core i uses bits [i*addr_width +: addr_width].
- wdata  input  core_count*data_width  packed per-core write data, same packing.
- ack  output  core_count  one-hot, one-cycle completion pulse to the granted core.
- rdata  output  data_width  read data; valid in the cycle ack is high for a read.
- busy  output  1  high while a transaction is in flight (states ISSUE or RESP).
- grant_id  output  clog2(core_count) (min 1)  index of the core currently or last served.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  addr_width  RAM address.
- mem_wdata  output  data_width  RAM write data.
- mem_rdata  input  data_width  RAM read data; valid the cycle after mem_en with mem_we=0.

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE, ack=0, rdata=0, busy=0, grant_id=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rr_ptr=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - eligible = req & ~ack. This masks the core being acked this cycle, so it cannot be re-granted while dropping req.
  - If eligible is nonzero: select the first set bit scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, …, core_count-1, 0, …).
  - On the selection edge: grant_id<=g, mem_en<=1, mem_we<=we[g], mem_addr<=addr slice g, mem_wdata<=wdata slice g, busy<=1, state<=ISSUE.
  - If eligible is zero: stay in IDLE; mem_en=0.
- ISSUE:
  - The RAM samples the registered mem_* on this edge.
  - Then mem_en<=0, mem_we<=0, state<=RESP.
  - mem_addr and mem_wdata hold their values.
- RESP:
  - For a read: rdata<=mem_rdata. For a write: rdata holds its previous value.
  - ack[grant_id]<=1, busy<=0.
  - rr_ptr<=(grant_id==core_count-1)?0:grant_id+1.
  - state<=IDLE.
- ack is cleared on the next edge, so it is exactly one cycle wide.
- Latency:
  - req first sampled high at edge k in IDLE with no contention: mem_en high in cycle (k,k+1); ack and rdata valid in cycle (k+2,k+3).
  - Peak throughput is one access per 3 cycles.
- Fairness:
  - After a core is served, it has lowest priority.
  - With all cores requesting continuously, grants rotate 0,1,…,core_count-1,0.
  - No core waits more than core_count-1 transactions.
- Requests that arrive or drop while a transaction is busy are ignored until IDLE.
- A req deasserted before ack is a protocol violation; the in-flight transaction still completes and acks.
- core_count=1: rr_ptr and grant_id stay 0; same 3-cycle sequence.
- Asynchronous reset in any state:
  - All registers go to reset values immediately; mem_en drops at once; any pending ack is lost.
  - A write whose mem_en was sampled before reset has committed; a write reset during IDLE→ISSUE before the RAM edge has not.
  - Cores must re-request after reset.

Test Plan:
- Reset then single read: mem[0x010]=0xABC; core0 req, we=0, addr=0x010 → mem_en for 1 cycle with addr 0x010, ack=2'b01 exactly 2 cycles after the sampling edge, rdata=0xABC, busy high for 2 cycles.
- Single write then read-back: core1 writes 0x5A5 to 0x0FF → mem_we=1, ack=2'b10; core1 reads 0x0FF → rdata=0x5A5, core0 ack never asserted.
- Simultaneous requests, core_count=2: both req high from reset and re-asserted after each ack for 6 transactions → grant order 0,1,0,1,0,1, each ack one cycle wide, no back-to-back duplicate grants.
- Ack masking: core0 holds req for one cycle after its ack, core1 idle → no second grant to core0 from that held cycle; rr_ptr=1 afterwards.
- Async reset mid-transaction: assert reset between clock edges during ISSUE → mem_en, busy, ack=0 immediately; after release, state IDLE, rr_ptr=0, fresh core1 request completes in 3 cycles.
- Wrap with core_count=3, parameter override: rr_ptr=2, requests on cores 0 and 1 → core0 granted first, then core1.
